// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants and FSM encoding for the RAM reader
package ram_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int RAM_ADDR_WIDTH = 9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_EMIT,
      ST_CSUM
   } state_e;

endpackage

// File: rtl/ram_reader_if.sv
// rtl/ram_reader_if.sv - control, RAM port B and byte stream bundle of the RAM reader
interface ram_reader_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
);

   logic                  start;
   logic [ADDR_WIDTH-1:0] addr_first;
   logic [ADDR_WIDTH-1:0] addr_last;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_dout;
   logic [7:0]            out_data;
   logic                  out_valid;
   logic                  out_ready;

   // master is the surrounding system (controller, RAM, consumer); slave is the reader
   modport master (
      output start, addr_first, addr_last, ram_dout, out_ready,
      input  busy, done, ram_addr, out_data, out_valid
   );

   modport slave (
      input  start, addr_first, addr_last, ram_dout, out_ready,
      output busy, done, ram_addr, out_data, out_valid
   );

endinterface

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - holds one RAM word and hands it out LSB byte first over valid/ready
module word_serializer
   import ram_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] word_i,
   input  logic        out_ready_i,
   output logic [7:0]  out_data_o,
   output logic        out_valid_o,
   output logic        last_byte_o
);

   logic [31:0] word_q;
   logic [1:0]  idx_q;
   logic        valid_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         word_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         word_q  <= word_i;
         idx_q   <= '0;
         valid_q <= 1'b1;
      end else if (valid_q && out_ready_i) begin
         if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
            valid_q <= 1'b0;
         end else begin
            idx_q <= idx_q + 2'd1;
         end
      end
   end

   assign out_data_o  = word_q[{idx_q, 3'b000} +: 8];
   assign out_valid_o = valid_q;
   assign last_byte_o = valid_q && out_ready_i && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/ram_reader.sv
// rtl/ram_reader.sv - walks a RAM port B address range and streams its words as bytes
// Optional trailing checksum byte: define RAM_READER_CHECKSUM_EN.
module ram_reader
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   ram_reader_if.slave bus
);

   generate
      if (DATA_WIDTH != 32) begin : g_bad_width
         $error("ram_reader: DATA_WIDTH must be 32");
      end
   endgenerate

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] ram_addr_q;
   logic [ADDR_WIDTH-1:0] addr_last_q;
   logic                  busy_q;
   logic                  done_q;

   logic                  ser_load;
   logic                  ser_valid;
   logic                  ser_last;
   logic [7:0]            ser_data;

`ifdef RAM_READER_CHECKSUM_EN
   logic [7:0]            sum_q;
   logic                  csum_valid_q;
`endif

   // RAM data for the address sampled at the end of FETCH is present during LOAD
   assign ser_load = (state_q == ST_LOAD);

   word_serializer u_ser (
      .clk_i       (clk),
      .rst_i       (rst),
      .load_i      (ser_load),
      .word_i      (bus.ram_dout),
      .out_ready_i (bus.out_ready),
      .out_data_o  (ser_data),
      .out_valid_o (ser_valid),
      .last_byte_o (ser_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ram_addr_q  <= '0;
         addr_last_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef RAM_READER_CHECKSUM_EN
         sum_q        <= '0;
         csum_valid_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef RAM_READER_CHECKSUM_EN
         if (ser_valid && bus.out_ready) begin
            sum_q <= sum_q + ser_data;
         end
`endif
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  ram_addr_q  <= bus.addr_first;
                  addr_last_q <= bus.addr_last;
                  busy_q      <= 1'b1;
                  state_q     <= ST_FETCH;
`ifdef RAM_READER_CHECKSUM_EN
                  sum_q       <= '0;
`endif
               end
            end
            ST_FETCH: state_q <= ST_LOAD;
            ST_LOAD:  state_q <= ST_EMIT;
            ST_EMIT: begin
               if (ser_last) begin
                  // address wraps naturally through the top of memory
                  if (ram_addr_q != addr_last_q) begin
                     ram_addr_q <= ram_addr_q + 1'b1;
                     state_q    <= ST_FETCH;
                  end else begin
`ifdef RAM_READER_CHECKSUM_EN
                     csum_valid_q <= 1'b1;
                     state_q      <= ST_CSUM;
`else
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
`endif
                  end
               end
            end
`ifdef RAM_READER_CHECKSUM_EN
            ST_CSUM: begin
               if (bus.out_ready) begin
                  csum_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            end
`endif
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.ram_addr = ram_addr_q;

`ifdef RAM_READER_CHECKSUM_EN
   assign bus.out_valid = ser_valid | csum_valid_q;
   assign bus.out_data  = csum_valid_q ? (8'd0 - sum_q) : ser_data;
`else
   assign bus.out_valid = ser_valid;
   assign bus.out_data  = ser_data;
`endif

endmodule

// File: tb/tb_ram_reader.sv
// tb/tb_ram_reader.sv - directed self-checking bench for ram_reader
module tb_ram_reader;

   logic clk;
   logic rst;

   ram_reader_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus ();

   ram_reader #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] mem [0:511];
   logic [7:0]  rx_q  [$];
   logic [7:0]  exp_q [$];
   logic [3:0]  rdy_pat;
   int          pass_cnt;
   int          total_cnt;
   int          stab_err;
   int          done_cnt;
   int          timed_out;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) bus.ram_dout <= mem[bus.ram_addr];

   task automatic add_csum();
`ifdef RAM_READER_CHECKSUM_EN
      logic [7:0] s;
      s = 8'd0;
      foreach (exp_q[i]) s = s + exp_q[i];
      exp_q.push_back(8'd0 - s);
`endif
   endtask

   task automatic do_start(input logic [8:0] f, input logic [8:0] l);
      @(negedge clk);
      bus.start      = 1'b1;
      bus.addr_first = f;
      bus.addr_last  = l;
      @(negedge clk);
      bus.start      = 1'b0;
      bus.addr_first = f ^ 9'h0AA;
      bus.addr_last  = l ^ 9'h055;
   endtask

   // mode 0: always ready; mode 1: ready follows rdy_pat 1,0,0,1
   task automatic collect(input int mode);
      logic       pv;
      logic       pr;
      logic [7:0] pd;
      logic       seen_done;
      int         post;
      rx_q.delete();
      stab_err  = 0;
      done_cnt  = 0;
      timed_out = 0;
      pv = 1'b0; pr = 1'b0; pd = 8'h00;
      seen_done = 1'b0;
      post = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (pv && !pr && !(bus.out_valid === 1'b1 && bus.out_data === pd)) stab_err++;
         bus.out_ready = (mode == 0) ? 1'b1 : rdy_pat[cyc % 4];
         if (bus.done === 1'b1) begin
            done_cnt++;
            seen_done = 1'b1;
         end
         if (bus.out_valid === 1'b1 && bus.out_ready) rx_q.push_back(bus.out_data);
         pv = bus.out_valid;
         pr = bus.out_ready;
         pd = bus.out_data;
         if (seen_done) post++;
         if (post > 6) break;
         @(negedge clk);
      end
      if (!seen_done) timed_out = 1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.done); else pass_cnt++;
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.ram_addr !== 9'd0) $display("FAIL reset_addr got %h exp 000", bus.ram_addr); else pass_cnt++;
      total_cnt++; if (bus.out_data !== 8'h00) $display("FAIL reset_data got %h exp 00", bus.out_data); else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat;
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      add_csum();
      do_start(9'd0, 9'd1);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      total_cnt++; if (lat !== 3) $display("FAIL basic_latency got %0d exp 3", lat); else pass_cnt++;
      collect(0);
      total_cnt++; if (timed_out !== 0) $display("FAIL basic_timeout got %0d exp 0", timed_out); else pass_cnt++;
      total_cnt++; if (rx_q.size() !== exp_q.size()) $display("FAIL basic_len got %0d exp %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
      foreach (exp_q[i]) begin
         total_cnt++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i])
            $display("FAIL basic_byte%0d got %h exp %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
         else pass_cnt++;
      end
      total_cnt++; if (done_cnt !== 1) $display("FAIL basic_done got %0d exp 1", done_cnt); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_after got %b exp 0", bus.busy); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      add_csum();
      do_start(9'd0, 9'd1);
      collect(1);
      total_cnt++; if (timed_out !== 0) $display("FAIL bp_timeout got %0d exp 0", timed_out); else pass_cnt++;
      total_cnt++; if (rx_q.size() !== exp_q.size()) $display("FAIL bp_len got %0d exp %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
      foreach (exp_q[i]) begin
         total_cnt++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i])
            $display("FAIL bp_byte%0d got %h exp %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
         else pass_cnt++;
      end
      total_cnt++; if (stab_err !== 0) $display("FAIL bp_stable got %0d exp 0", stab_err); else pass_cnt++;
      total_cnt++; if (done_cnt !== 1) $display("FAIL bp_done got %0d exp 1", done_cnt); else pass_cnt++;
   endtask

   task automatic test_wrap();
      mem[511] = 32'h11111111;
      mem[0]   = 32'h22222222;
      mem[1]   = 32'h33333333;
      exp_q = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                8'h33, 8'h33, 8'h33, 8'h33};
      add_csum();
      do_start(9'd511, 9'd1);
      total_cnt++; if (bus.ram_addr !== 9'd511) $display("FAIL wrap_first_addr got %0d exp 511", bus.ram_addr); else pass_cnt++;
      collect(1);
      total_cnt++; if (timed_out !== 0) $display("FAIL wrap_timeout got %0d exp 0", timed_out); else pass_cnt++;
      total_cnt++; if (rx_q.size() !== exp_q.size()) $display("FAIL wrap_len got %0d exp %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
      foreach (exp_q[i]) begin
         total_cnt++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i])
            $display("FAIL wrap_byte%0d got %h exp %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
         else pass_cnt++;
      end
      total_cnt++; if (bus.ram_addr !== 9'd1) $display("FAIL wrap_last_addr got %0d exp 1", bus.ram_addr); else pass_cnt++;
      total_cnt++; if (done_cnt !== 1) $display("FAIL wrap_done got %0d exp 1", done_cnt); else pass_cnt++;
   endtask

   task automatic test_single_and_busy_start();
      int busy_seen;
      mem[5] = 32'hA5B6C7D8;
      exp_q = '{8'hD8, 8'hC7, 8'hB6, 8'hA5};
      add_csum();
      bus.out_ready = 1'b0;
      do_start(9'd5, 9'd5);
      do_start(9'd0, 9'd1);
      collect(0);
      total_cnt++; if (timed_out !== 0) $display("FAIL single_timeout got %0d exp 0", timed_out); else pass_cnt++;
      total_cnt++; if (rx_q.size() !== exp_q.size()) $display("FAIL single_len got %0d exp %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
      foreach (exp_q[i]) begin
         total_cnt++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i])
            $display("FAIL single_byte%0d got %h exp %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
         else pass_cnt++;
      end
      total_cnt++; if (done_cnt !== 1) $display("FAIL single_done got %0d exp 1", done_cnt); else pass_cnt++;
      busy_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.busy !== 1'b0) busy_seen++;
      end
      total_cnt++; if (busy_seen !== 0) $display("FAIL single_no_requeue got %0d exp 0", busy_seen); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int n;
      int d;
      mem[0] = 32'h04030201;
      mem[1] = 32'h08070605;
      do_start(9'd0, 9'd1);
      bus.out_ready = 1'b1;
      n = 0;
      while (!(bus.out_valid === 1'b1 && bus.out_data === 8'h02) && n < 50) begin
         @(negedge clk);
         n++;
      end
      total_cnt++; if (n >= 50) $display("FAIL rstmid_wait got %0d exp <50", n); else pass_cnt++;
      rst = 1'b1;
      @(negedge clk);
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", bus.busy); else pass_cnt++;
      rst = 1'b0;
      bus.out_ready = 1'b0;
      d = (bus.done === 1'b1) ? 1 : 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.done === 1'b1) d++;
      end
      total_cnt++; if (d !== 0) $display("FAIL rstmid_done got %0d exp 0", d); else pass_cnt++;
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      add_csum();
      do_start(9'd0, 9'd1);
      collect(0);
      total_cnt++; if (rx_q.size() !== exp_q.size()) $display("FAIL rstmid_len got %0d exp %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
      foreach (exp_q[i]) begin
         total_cnt++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i])
            $display("FAIL rstmid_byte%0d got %h exp %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
         else pass_cnt++;
      end
   endtask

   initial begin
      pass_cnt       = 0;
      total_cnt      = 0;
      rdy_pat        = 4'b1001;
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.addr_first = '0;
      bus.addr_last  = '0;
      bus.out_ready  = 1'b0;
      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      mem[0] = 32'h04030201;
      mem[1] = 32'h08070605;

      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      mem[0] = 32'h04030201;
      mem[1] = 32'h08070605;
      test_single_and_busy_start();
      test_reset_mid();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ram_reader.md
Name: ram_reader

Overview:
- Read-side counterpart to the block that fills the dual-port block RAM through port A.
- Walks an address range on RAM port B and serialises each 32-bit word into 8-bit bytes, least-significant byte first.
- Bytes leave on a valid/ready stream toward UART TX or the LED debug path.
- Sits between the RAM read port and any byte-wide consumer.

Parameters:
- ADDR_WIDTH, 9, RAM word-address width; matches the RAM instance.
- DATA_WIDTH, 32, RAM word width; fixed at 32; another value is a elaboration-time error.

Ports:
- clk  input  1  system clock; RAM and reader share it.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- addr_first  input  ADDR_WIDTH  first word address; latched on accepted start.
- addr_last  input  ADDR_WIDTH  last word address, inclusive; latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the final byte handshake.
- ram_addr  output  ADDR_WIDTH  registered address to RAM port B.
- ram_dout  input  DATA_WIDTH  RAM port B data; valid one cycle after ram_addr is sampled.
- out_data  output  8  current byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the byte.

Behaviour:
- Reset: the FSM goes to IDLE. busy, done, out_valid, ram_addr, out_data, the byte index and the word register all clear to 0.
- Reset mid-transfer:
  - Aborts in the same edge.
  - No done pulse.
  - Any pending byte is dropped.
- States and transitions:
  - IDLE: on start=1, latch addr_first/addr_last, set ram_addr<=addr_first, set busy<=1, go to FETCH.
  - FETCH: RAM samples ram_addr at the end of this cycle; go to LOAD.
  - LOAD: capture ram_dout into the word register; set byte index to 0; set out_valid<=1; go to EMIT.
  - EMIT: out_data = word[8*idx+7 : 8*idx]. Take no action unless out_valid&&out_ready.
    - idx<3: idx+1.
    - idx==3 and ram_addr != addr_last_latched: ram_addr+1 (modulo 2^ADDR_WIDTH), clear out_valid, go to FETCH.
    - idx==3 and ram_addr == addr_last_latched: clear out_valid and busy, pulse done, go to IDLE.
- Latency:
  - First out_valid rises 3 cycles after the accepted start edge.
  - Inter-word gap is 2 idle cycles (FETCH, LOAD) when the consumer is always ready.
- Stream rules:
  - out_valid never drops and out_data never changes until the handshake completes.
  - out_ready is ignored when out_valid=0.
- Range rules:
  - addr_last < addr_first wraps through the top of memory. Word count is (addr_last-addr_first) mod 2^ADDR_WIDTH, plus 1.
  - addr_first == addr_last reads exactly one word (4 bytes).
- start while busy is ignored; no queueing.
- addr_first/addr_last changes after acceptance have no effect.
- done and start in the same cycle: done is registered, the FSM is already in IDLE, so the start is accepted.
- The RAM must not be written at the address being read in the same cycle. The read-during-write result is undefined and is the integrator's responsibility.

Optional Feature:
- Macro: RAM_READER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of all emitted data bytes.
  - After the last data byte handshake, the FSM enters CSUM and presents the two's complement of the sum with out_valid=1.
  - On handshake it pulses done and returns to IDLE.
  - The sum clears on accepted start and on rst.
  - The sum of all bytes including the checksum is 0.
- Undefined: no CSUM state and no sum register; behaviour is exactly as above.

Decomposition:
- Shared package ram_pkg:
  - FSM state encoding (IDLE, FETCH, LOAD, EMIT, CSUM).
  - BYTES_PER_WORD = 4.
  - RAM_ADDR_WIDTH default 9.
- Sub-module word_serializer:
  - Holds the word register, byte index and valid/ready logic; emits last_byte on the idx==3 handshake.
  - ram_reader keeps the address FSM.

Test Plan:
- RAM preloaded with word[0]=0x04030201, word[1]=0x08070605; start with first=0, last=1, out_ready=1 -> bytes 01,02,03,04,05,06,07,08; first valid 3 cycles after start; done pulses once; busy low after.
- Same run, out_ready toggling 1,0,0,1 pseudo-randomly -> identical byte sequence; out_data stable while valid&&!ready.
- first=511, last=1 with words 0x11111111, 0x22222222, 0x33333333 at 511, 0, 1 -> 12 bytes in order 11×4, 22×4, 33×4; ram_addr wraps 511->0.
- first=last=5 -> exactly 4 bytes then done; start pulsed while busy -> no second transfer.
- rst asserted during byte 2 of word 0 -> next cycle out_valid=0, busy=0, no done; a subsequent start reads from addr_first again.
- With RAM_READER_CHECKSUM_EN, reading 0x04030201 -> data bytes 01,02,03,04 then checksum byte F6 (sum 0x0A, negated); done after the F6 handshake.
